// File: rtl/pcie_req_arbiter.sv
// Packet-level round-robin arbiter feeding the PCIe request CDC FIFO write port.
// A grant is held for a whole packet; a starved grant is force-released after TIMEOUT cycles.
module pcie_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*73-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_wr,
    output logic [72:0]          o_wdata,
    input  logic                 i_wfull,
    output logic                 o_busy,
    output logic [2:0]           o_grant_id,
    output logic                 o_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  rr_ptr_r;
    logic [2:0]  rr_ptr_s;
    logic [2:0]  grant_r;
    logic [2:0]  grant_s;
    logic [2:0]  sel_s;
    logic [2:0]  next_ptr_s;
    logic [15:0] starve_r;
    logic [15:0] starve_s;
    logic        err_r;
    logic        err_s;
    logic        found_s;
    logic        valid_g_s;
    logic        xfer_s;
    logic        starving_s;
    logic        timeout_s;
    logic [72:0] wdata_s;
    logic [NREQ-1:0] ready_s;

    // Mux the granted requester's valid and beat
    always_comb begin
        valid_g_s = 1'b0;
        wdata_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_r == i[2:0]) begin
                valid_g_s = i_req_valid[i];
                wdata_s   = i_req_data[73*i +: 73];
            end else begin
                valid_g_s = valid_g_s;
            end
        end
    end

    // First valid requester at or after rr_ptr, cyclically
    always_comb begin : rr_pick
        int idx;
        idx     = 0;
        sel_s   = rr_ptr_r;
        found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_r) + i) % NREQ;
            if (!found_s && i_req_valid[idx]) begin
                found_s = 1'b1;
                sel_s   = idx[2:0];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign next_ptr_s = (grant_r == 3'(NREQ-1)) ? 3'd0 : grant_r + 3'd1;
    assign xfer_s     = (state_r == BUSY) && valid_g_s && !i_wfull;
    assign starving_s = (state_r == BUSY) && !valid_g_s && !i_wfull;
    // Firing on the increment that would reach TIMEOUT-1 makes o_err land on the TIMEOUT-th starved cycle
    assign timeout_s  = starving_s && (starve_r == 16'(TIMEOUT-2));

    // Next-state and register-input logic
    always_comb begin
        state_s  = state_r;
        rr_ptr_s = rr_ptr_r;
        grant_s  = grant_r;
        starve_s = starve_r;
        err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s  = BUSY;
                    grant_s  = sel_s;
                    starve_s = 16'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (xfer_s && wdata_s[72]) begin
                    state_s  = IDLE;
                    rr_ptr_s = next_ptr_s;
                    starve_s = 16'd0;
                end else if (xfer_s) begin
                    starve_s = 16'd0;
                end else if (timeout_s) begin
                    state_s  = IDLE;
                    rr_ptr_s = next_ptr_s;
                    err_s    = 1'b1;
                end else if (starving_s) begin
                    starve_s = starve_r + 16'd1;
                end else begin
                    starve_s = starve_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r  <= IDLE;
            rr_ptr_r <= 3'd0;
            grant_r  <= 3'd0;
            starve_r <= 16'd0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            grant_r  <= grant_s;
            starve_r <= starve_s;
            err_r    <= err_s;
        end
    end

    // Only the granted requester may see ready
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_r == i[2:0]) begin
                ready_s[i] = xfer_s;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    assign o_req_ready = ready_s;
    assign o_wr        = xfer_s;
    assign o_wdata     = wdata_s;
    assign o_busy      = (state_r == BUSY);
    assign o_grant_id  = grant_r;
    assign o_err       = err_r;

endmodule
